// File: rtl/cam_pkg.sv
// Shared CAM definitions: default geometry and the match-line pair encoding.
package cam_pkg;

  localparam int unsigned CAM_WIDTH     = 32;
  localparam int unsigned CAM_NUM_WORDS = 16;

  // Offsets of the two lines that describe word bit i on the search bus.
  localparam int unsigned BIT_ONE  = 0;  // line 2i: bit i must be 1
  localparam int unsigned BIT_ZERO = 1;  // line 2i+1: bit i must be 0

  // Build search lines from a comparand and a care mask (0 = don't-care).
  function automatic logic [2*CAM_WIDTH-1:0] ml_encode(
    input logic [CAM_WIDTH-1:0] comparand,
    input logic [CAM_WIDTH-1:0] care
  );
    logic [2*CAM_WIDTH-1:0] ml;
    ml = '0;
    for (int i = 0; i < int'(CAM_WIDTH); i++) begin
      ml[2*i+int'(BIT_ONE)]  = care[i] & comparand[i];
      ml[2*i+int'(BIT_ZERO)] = care[i] & ~comparand[i];
    end
    return ml;
  endfunction

endpackage

// File: rtl/cam_priority_encoder.sv
// Lowest-index-first responder resolution over a tag vector.
module cam_priority_encoder #(
  parameter int unsigned NUM_WORDS = 16,
  parameter int unsigned ADDR_W    = $clog2(NUM_WORDS)
) (
  input  logic [NUM_WORDS-1:0] i_tags,
  output logic                 o_any_resp,
  output logic [ADDR_W-1:0]    o_first_addr
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    o_first_addr = '0;
    for (int i = int'(NUM_WORDS) - 1; i >= 0; i--) begin
      if (i_tags[i]) o_first_addr = ADDR_W'(i);
    end
  end

  assign o_any_resp = |i_tags;

endmodule

// File: rtl/cam_word_array.sv
// CAM word storage with parallel ternary match, tag latching, responder
// resolution, addressed writes and masked multi-writes to tagged words.
module cam_word_array
  import cam_pkg::*;
#(
  parameter  int unsigned NUM_WORDS = CAM_NUM_WORDS,
  parameter  int unsigned WIDTH     = CAM_WIDTH,
  localparam int unsigned ADDR_W    = $clog2(NUM_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2*WIDTH-1:0]   match_lines,
  input  logic                 search_en,
  input  logic                 wr_en,
  input  logic                 wr_multi,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [WIDTH-1:0]     wr_mask,
  input  logic                 step,
  output logic [NUM_WORDS-1:0] tags,
  output logic                 any_resp,
  output logic [ADDR_W-1:0]    first_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0]     r_word [NUM_WORDS];
  logic [NUM_WORDS-1:0] r_valid;
  logic [NUM_WORDS-1:0] r_tags;

  logic [WIDTH-1:0]     w_need_one;
  logic [WIDTH-1:0]     w_need_zero;
  logic [NUM_WORDS-1:0] w_match;
  logic                 w_addr_ok;
  logic [NUM_WORDS-1:0] w_addr_sel;
  logic [NUM_WORDS-1:0] w_wr_sel;
  logic                 w_any_resp;
  logic [ADDR_W-1:0]    w_first_addr;
  logic [NUM_WORDS-1:0] w_first_onehot;

  // Split the search bus into per-bit "must be 1" and "must be 0" vectors.
  always_comb begin
    w_need_one  = '0;
    w_need_zero = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_need_one[i]  = match_lines[2*i+int'(BIT_ONE)];
      w_need_zero[i] = match_lines[2*i+int'(BIT_ZERO)];
    end
  end

  // Parallel compare: a word matches when valid and no constrained bit disagrees.
  always_comb begin
    w_match = '0;
    for (int w = 0; w < int'(NUM_WORDS); w++) begin
      w_match[w] = r_valid[w] &
                   ~(|((w_need_one & ~r_word[w]) | (w_need_zero & r_word[w])));
    end
  end

  // Write target selection: one addressed word, or every currently tagged word.
  always_comb begin
    w_addr_ok  = 32'(wr_addr) < NUM_WORDS;
    w_addr_sel = '0;
    for (int w = 0; w < int'(NUM_WORDS); w++) begin
      w_addr_sel[w] = wr_en & ~wr_multi & w_addr_ok & (wr_addr == ADDR_W'(w));
    end
    w_wr_sel = w_addr_sel | ({NUM_WORDS{wr_en & wr_multi}} & r_tags);
  end

  // Word storage and valid bits; masked update keeps unselected bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < int'(NUM_WORDS); w++) r_word[w] <= '0;
      r_valid <= '0;
    end else begin
      for (int w = 0; w < int'(NUM_WORDS); w++) begin
        if (w_wr_sel[w]) r_word[w] <= (r_word[w] & ~wr_mask) | (wr_data & wr_mask);
      end
      r_valid <= r_valid | w_addr_sel;
    end
  end

  cam_priority_encoder #(
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_prio (
    .i_tags       (r_tags),
    .o_any_resp   (w_any_resp),
    .o_first_addr (w_first_addr)
  );

  assign w_first_onehot = NUM_WORDS'(w_any_resp) << w_first_addr;

  // Tag register: a search reloads all tags and overrides a step clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tags <= '0;
    end else if (search_en) begin
      r_tags <= w_match;
    end else if (step) begin
      r_tags <= r_tags & ~w_first_onehot;
    end
  end

  assign tags       = r_tags;
  assign any_resp   = w_any_resp;
  assign first_addr = w_first_addr;
  assign rd_data    = w_any_resp ? r_word[w_first_addr] : '0;

endmodule
